// File: rtl/reg_pair_sequencer_if.sv
// Request/completion and register-file port bundle for reg_pair_sequencer.
// master = the sequencer; slave = the core and register file it talks to.
interface reg_pair_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic                  start;
  logic [1:0]            op;
  logic [3:0]            dst_pair;
  logic [3:0]            src_pair;
  logic [5:0]            imm;
  logic                  busy;
  logic                  done;
  logic [2*DATA_W-1:0]   result;
  logic [4:0]            flags;
  logic                  flags_we;
  logic [ADDR_W-1:0]     rf_RA1;
  logic [ADDR_W-1:0]     rf_RA2;
  logic [ADDR_W-1:0]     rf_WA;
  logic                  rf_RegWrite;
  logic [DATA_W-1:0]     rf_WD;
  logic [DATA_W-1:0]     rf_RD1;
  logic [DATA_W-1:0]     rf_RD2;

  modport master (
    input  start, op, dst_pair, src_pair, imm, rf_RD1, rf_RD2,
    output busy, done, result, flags, flags_we,
           rf_RA1, rf_RA2, rf_WA, rf_RegWrite, rf_WD
  );

  modport slave (
    output start, op, dst_pair, src_pair, imm, rf_RD1, rf_RD2,
    input  busy, done, result, flags, flags_we,
           rf_RA1, rf_RA2, rf_WA, rf_RegWrite, rf_WD
  );
endinterface

// File: rtl/reg_pair_sequencer.sv
// 16-bit register-pair ops (MOVW/ADIW/SBIW/PINC) over an 8-bit two-read/one-write file.
// Optional macro REG_PAIR_FLAGS_EN enables the SREG flag outputs; otherwise flags/flags_we are 0.
module reg_pair_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  clr_n,
  reg_pair_sequencer_if.master  bus
);
  localparam int PW = 2 * DATA_W;
  localparam logic [1:0] OP_MOVW = 2'b00;
  localparam logic [1:0] OP_ADIW = 2'b01;
  localparam logic [1:0] OP_SBIW = 2'b10;

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WR_LO, WR_HI, DONE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      op_reg;
  logic [3:0]      dst_reg;
  logic [3:0]      src_reg;
  logic [5:0]      imm_reg;
  logic [PW-1:0]   calc_reg, calc_next;
  logic [PW-1:0]   result_reg;
  logic [PW-1:0]   pair_val;
  logic [3:0]      rd_pair;
  logic            is_arith;

  assign pair_val = {bus.rf_RD2, bus.rf_RD1};
  assign rd_pair  = (op_reg == OP_MOVW) ? src_reg : dst_reg;
  assign is_arith = (op_reg == OP_ADIW) || (op_reg == OP_SBIW);

  always_comb begin
    calc_next = pair_val;
    case (op_reg)
      OP_MOVW: calc_next = pair_val;
      OP_ADIW: calc_next = pair_val + PW'(imm_reg);
      OP_SBIW: calc_next = pair_val - PW'(imm_reg);
      default: calc_next = pair_val + PW'(1);
    endcase
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      dst_reg    <= '0;
      src_reg    <= '0;
      imm_reg    <= '0;
      calc_reg   <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && bus.start) begin
        op_reg  <= bus.op;
        dst_reg <= bus.dst_pair;
        src_reg <= bus.src_pair;
        imm_reg <= bus.imm;
      end
      if (state_reg == CAPTURE) calc_reg <= calc_next;
      // result only changes as DONE is entered, so it is stable between completions
      if (state_reg == WR_HI) result_reg <= calc_reg;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bus.busy        = (state_reg != IDLE);
    bus.done        = 1'b0;
    bus.result      = result_reg;
    bus.rf_RA1      = '0;
    bus.rf_RA2      = '0;
    bus.rf_WA       = '0;
    bus.rf_RegWrite = 1'b0;
    bus.rf_WD       = '0;
    case (state_reg)
      IDLE:    if (bus.start) state_next = READ;
      READ: begin
        bus.rf_RA1 = ADDR_W'({rd_pair, 1'b0});
        bus.rf_RA2 = ADDR_W'({rd_pair, 1'b1});
        state_next = CAPTURE;
      end
      CAPTURE: state_next = WR_LO;
      WR_LO: begin
        bus.rf_WA       = ADDR_W'({dst_reg, 1'b0});
        bus.rf_WD       = calc_reg[DATA_W-1:0];
        bus.rf_RegWrite = 1'b1;
        state_next      = WR_HI;
      end
      WR_HI: begin
        bus.rf_WA       = ADDR_W'({dst_reg, 1'b1});
        bus.rf_WD       = calc_reg[PW-1:DATA_W];
        bus.rf_RegWrite = 1'b1;
        state_next      = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef REG_PAIR_FLAGS_EN
  logic [4:0] flags_calc, flags_pend_reg, flags_reg;
  logic       r15, rdh7, flag_c, flag_v;

  assign r15  = calc_next[PW-1];
  assign rdh7 = pair_val[PW-1];

  always_comb begin
    flag_c = ~r15 & rdh7;
    flag_v = ~rdh7 & r15;
    if (op_reg == OP_SBIW) begin
      flag_c = r15 & ~rdh7;
      flag_v = rdh7 & ~r15;
    end
    flags_calc = {r15 ^ flag_v, flag_v, r15, (calc_next == '0), flag_c};
  end

  // Flags are computed alongside the result but only published as DONE is entered.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      flags_pend_reg <= '0;
      flags_reg      <= '0;
    end else begin
      if (state_reg == CAPTURE) flags_pend_reg <= flags_calc;
      if (state_reg == WR_HI && is_arith) flags_reg <= flags_pend_reg;
    end
  end

  assign bus.flags    = flags_reg;
  assign bus.flags_we = (state_reg == DONE) && is_arith;
`else
  logic unused_arith;
  assign unused_arith = is_arith;
  assign bus.flags    = '0;
  assign bus.flags_we = 1'b0;
`endif
endmodule

// File: tb/tb_reg_pair_sequencer.sv
// Randomized scoreboard bench for reg_pair_sequencer with a behavioural register file
// and an arithmetic reference model of the 16-bit pair operations.
module tb_reg_pair_sequencer;
`ifdef REG_PAIR_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] result;
    logic        fwe;
    logic [4:0]  flags;
  } exp_t;

  typedef struct {
    logic [4:0] wa;
    logic [7:0] wd;
  } wr_t;

  logic clock = 1'b0;
  logic clr_n = 1'b1;
  always #5 clock = ~clock;

  reg_pair_sequencer_if bus ();
  reg_pair_sequencer dut (.clock(clock), .clr_n(clr_n), .bus(bus));

  // Register file environment: 1-cycle registered reads, one write port plus a preload port.
  logic [7:0] rf_mem [32];
  logic       pl_en   = 1'b0;
  logic [4:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  always @(posedge clock) begin
    if (pl_en) rf_mem[pl_addr] <= pl_data;
    if (bus.rf_RegWrite) rf_mem[bus.rf_WA] <= bus.rf_WD;
    bus.rf_RD1 <= rf_mem[bus.rf_RA1];
    bus.rf_RD2 <= rf_mem[bus.rf_RA2];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [7:0] model [32];
  logic [4:0] model_flags = '0;
  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   done_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes the register file or completes.
  always @(negedge clock) begin
    exp_t e;
    wr_t  w;
    if (clr_n) begin
      if (bus.rf_RegWrite) begin
        if (wr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_unexpected: WA=%0d WD=0x%02h with no write expected", bus.rf_WA, bus.rf_WD);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", 32'(bus.rf_WA), 32'(w.wa));
          check("wr_data", 32'(bus.rf_WD), 32'(w.wd));
        end
      end
      if (bus.done) begin
        done_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_unexpected: result=0x%04h with no operation pending", bus.result);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] done cyc=%0d result=0x%04h flags=%05b we=%0b", cyc, bus.result, bus.flags, bus.flags_we);
          check("result", 32'(bus.result), 32'(e.result));
          check("flags_we", 32'(bus.flags_we), 32'(e.fwe));
          check("flags", 32'(bus.flags), 32'(e.flags));
        end
      end
    end
  end

  // Reference model: 16-bit arithmetic on integers, overflow/borrow judged by range.
  task automatic ref_push(input logic [1:0] o, input logic [3:0] d, input logic [3:0] s,
                          input logic [5:0] i);
    int p, r, sr, full, res;
    logic c, v, n, z, arith;
    exp_t e;
    wr_t  w;
    p  = (o == 2'b00) ? int'(s) : int'(d);
    r  = int'({model[2*p+1], model[2*p]});
    sr = (r >= 32768) ? r - 65536 : r;
    c = 1'b0; v = 1'b0;
    arith = (o == 2'b01) || (o == 2'b10);
    case (o)
      2'b00: full = r;
      2'b01: begin full = r + int'(i); c = (full > 65535); v = (sr + int'(i) > 32767); end
      2'b10: begin full = r - int'(i); c = (full < 0);     v = (sr - int'(i) < -32768); end
      default: full = r + 1;
    endcase
    res = full & 65535;
    n = (res >= 32768);
    z = (res == 0);
    if (arith) model_flags = {n ^ v, v, n, z, c};
    w.wa = 5'(2 * int'(d));     w.wd = 8'(res);      wr_q.push_back(w);
    w.wa = 5'(2 * int'(d) + 1); w.wd = 8'(res >> 8); wr_q.push_back(w);
    model[2*int'(d)]   = 8'(res);
    model[2*int'(d)+1] = 8'(res >> 8);
    e.result = 16'(res);
    e.fwe    = FLAGS_EN && arith;
    e.flags  = FLAGS_EN ? model_flags : 5'b0;
    exp_q.push_back(e);
  endtask

  task automatic preload(input int a, input logic [7:0] v);
    @(posedge clock); #1;
    pl_en = 1'b1; pl_addr = 5'(a); pl_data = v; model[a] = v;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  task automatic preload_pair(input int p, input logic [15:0] v);
    preload(2*p, v[7:0]);
    preload(2*p+1, v[15:8]);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [3:0] d, input logic [3:0] s,
                       input logic [5:0] i);
    int n, bz;
    bit got;
    ref_push(o, d, s, i);
    @(posedge clock); #1;
    bus.start = 1'b1; bus.op = o; bus.dst_pair = d; bus.src_pair = s; bus.imm = i;
    @(posedge clock); #1;
    bus.start    = 1'b0;
    bus.op       = 2'($urandom_range(0, 3));
    bus.dst_pair = 4'($urandom_range(0, 15));
    bus.src_pair = 4'($urandom_range(0, 15));
    bus.imm      = 6'($urandom_range(0, 63));
    n = 0; bz = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clock);
      n++;
      if (bus.busy) bz++;
      if (bus.done) got = 1'b1;
    end
    $display("[TB] op=%0d dst=%0d src=%0d imm=%0d latency=%0d busy=%0d", o, d, s, i, n, bz);
    check("done_latency", 32'(got ? n : -1), 32'd5);
    check("busy_cycles", 32'(bz), 32'd5);
    @(negedge clock);
    check("idle_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    logic [1:0]  o;
    logic [3:0]  d, s;
    logic [5:0]  i;
    logic [15:0] bnd [6];
    bnd[0] = 16'hFFFF; bnd[1] = 16'h0000; bnd[2] = 16'h7FFF;
    bnd[3] = 16'h8000; bnd[4] = 16'hFFC0; bnd[5] = 16'h003F;
    bus.start = 1'b0; bus.op = '0; bus.dst_pair = '0; bus.src_pair = '0; bus.imm = '0;

    #1 clr_n = 1'b0;
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_flags_we", 32'(bus.flags_we), 32'd0);
    check("rst_regwrite", 32'(bus.rf_RegWrite), 32'd0);
    @(negedge clock); clr_n = 1'b1;

    for (int k = 0; k < 32; k++) preload(k, 8'($urandom_range(0, 255)));

    preload_pair(12, 16'h00FF);
    do_op(2'b01, 4'd12, 4'd0, 6'd1);
    check("tp_adiw_result", 32'(bus.result), 32'h0100);
    check("tp_adiw_flags", 32'(bus.flags), FLAGS_EN ? 32'h00 : 32'h00);

    preload_pair(13, 16'h0000);
    do_op(2'b10, 4'd13, 4'd0, 6'd1);
    check("tp_sbiw_result", 32'(bus.result), 32'hFFFF);
    check("tp_sbiw_flags", 32'(bus.flags), FLAGS_EN ? 32'b10101 : 32'h00);
    check("tp_sbiw_r26", 32'(rf_mem[26]), 32'hFF);
    check("tp_sbiw_r27", 32'(rf_mem[27]), 32'hFF);

    preload_pair(15, 16'h7FC1);
    do_op(2'b01, 4'd15, 4'd0, 6'd63);
    check("tp_adiw_ovf_result", 32'(bus.result), 32'h8000);
    check("tp_adiw_ovf_flags", 32'(bus.flags), FLAGS_EN ? 32'b01100 : 32'h00);

    preload_pair(1, 16'hBEEF);
    do_op(2'b00, 4'd0, 4'd1, 6'd0);
    check("tp_movw_r0", 32'(rf_mem[0]), 32'hEF);
    check("tp_movw_r1", 32'(rf_mem[1]), 32'hBE);
    check("tp_movw_flags_held", 32'(bus.flags), FLAGS_EN ? 32'b01100 : 32'h00);

    // PINC with start held for 10 cycles: second request enters one IDLE cycle after DONE.
    preload_pair(14, 16'hFFFF);
    ref_push(2'b11, 4'd14, 4'd0, 6'd0);
    ref_push(2'b11, 4'd14, 4'd0, 6'd0);
    done_cyc_q.delete();
    @(posedge clock); #1;
    bus.start = 1'b1; bus.op = 2'b11; bus.dst_pair = 4'd14;
    repeat (10) @(posedge clock);
    #1 bus.start = 1'b0;
    n = 0;
    while (done_cyc_q.size() < 2 && n < 40) begin @(negedge clock); n++; end
    check("pinc_done_count", 32'(done_cyc_q.size()), 32'd2);
    if (done_cyc_q.size() >= 2)
      check("pinc_done_gap", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'd6);
    repeat (3) @(negedge clock);
    check("pinc_r28", 32'(rf_mem[28]), 32'h01);
    check("pinc_r29", 32'(rf_mem[29]), 32'h00);
    check("pinc_no_extra", 32'(exp_q.size()), 32'd0);

    // Reset during WR_HI: low byte lands, high byte and done are abandoned.
    preload_pair(12, 16'h12FF);
    begin
      wr_t w;
      w.wa = 5'd24; w.wd = 8'h00;
      wr_q.push_back(w);
    end
    model[24] = 8'h00;
    @(posedge clock); #1;
    bus.start = 1'b1; bus.op = 2'b01; bus.dst_pair = 4'd12; bus.imm = 6'd1;
    @(posedge clock); #1 bus.start = 1'b0;
    repeat (2) @(posedge clock);
    @(posedge clock); #2;
    check("rst_mid_in_wr_hi", 32'(bus.rf_RegWrite), 32'd1);
    clr_n = 1'b0;
    #1;
    check("rst_mid_regwrite", 32'(bus.rf_RegWrite), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_result", 32'(bus.result), 32'd0);
    model_flags = '0;
    repeat (3) @(negedge clock);
    clr_n = 1'b1;
    repeat (4) @(negedge clock);
    check("rst_mid_r24", 32'(rf_mem[24]), 32'h00);
    check("rst_mid_r25", 32'(rf_mem[25]), 32'h12);
    check("rst_mid_wr_drained", 32'(wr_q.size()), 32'd0);
    do_op(2'b01, 4'd12, 4'd0, 6'd1);
    check("post_rst_result", 32'(bus.result), 32'h1201);

    for (int k = 0; k < 40; k++) begin
      o = 2'($urandom_range(0, 3));
      d = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(0, 15));
      i = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0)
        preload_pair((o == 2'b00) ? int'(s) : int'(d), bnd[$urandom_range(0, 5)]);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      do_op(o, d, s, i);
    end

    repeat (3) @(negedge clock);
    for (int k = 0; k < 32; k++) check($sformatf("rf_final_r%0d", k), 32'(rf_mem[k]), 32'(model[k]));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
